// File: rtl/vga_sync_gen.sv
// 640x480 VGA raster timing generator: hsync/vsync, data-enable and pixel coordinates from one pixel clock.
// Optional `VGA_SYNC_FRAME_CNT_EN adds an 8-bit frame counter output frame_cnt.

module vga_sync_gen_chk (
  input logic       clk,
  input logic       clr,
  input logic       hsync,
  input logic       de,
  input logic       frame_start,
  input logic [9:0] x,
  input logic [9:0] y
);

  // Sync pulses live in blanking, and the first pixel of a frame is always visible
  a_de_hsync: assert property (@(posedge clk) disable iff (clr) de |-> hsync);
  a_fs_de:    assert property (@(posedge clk) disable iff (clr) frame_start |-> de);
  a_xy_zero:  assert property (@(posedge clk) disable iff (clr) !de |-> (x == 10'd0 && y == 10'd0));

endmodule

module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic [7:0] frame_cnt,
`endif
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SB_C   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SB_C   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [9:0] h_r;
  logic [9:0] h_s;
  logic [9:0] v_r;
  logic [9:0] v_s;
  logic       run_s;
  logic       de_s;
  logic       fs_s;

  // State and raster counter registers; clr returns to IDLE immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      h_r     <= 10'd0;
      v_r     <= 10'd0;
    end else begin
      state_r <= state_s;
      h_r     <= h_s;
      v_r     <= v_s;
    end
  end

  // Next-state and counter advance; start only matters at the frame wrap point
  always_comb begin
    state_s = state_r;
    h_s     = h_r;
    v_s     = v_r;
    case (state_r)
      IDLE: begin
        h_s = 10'd0;
        v_s = 10'd0;
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (h_r == H_LAST_C) begin
          h_s = 10'd0;
          if (v_r == V_LAST_C) begin
            v_s = 10'd0;
            if (start) begin
              state_s = RUN;
            end else begin
              state_s = IDLE;
            end
          end else begin
            v_s     = v_r + 10'd1;
            state_s = RUN;
          end
        end else begin
          h_s     = h_r + 10'd1;
          v_s     = v_r;
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        h_s     = 10'd0;
        v_s     = 10'd0;
      end
    endcase
  end

  // Output decode from registers only, so clr reaches the outputs without a clock
  always_comb begin
    run_s       = (state_r == RUN);
    de_s        = run_s && (h_r < H_ACT_C) && (v_r < V_ACT_C);
    fs_s        = run_s && (h_r == 10'd0) && (v_r == 10'd0);
    hsync       = !(run_s && (h_r >= H_SB_C) && (h_r < H_SE_C));
    vsync       = !(run_s && (v_r >= V_SB_C) && (v_r < V_SE_C));
    de          = de_s;
    frame_start = fs_s;
    if (de_s) begin
      x = h_r;
      y = v_r;
    end else begin
      x = 10'd0;
      y = 10'd0;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Frame counter advances on each frame_start and holds through IDLE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_cnt_r <= 8'd0;
    end else if (fs_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  vga_sync_gen_chk u_chk (
    .clk         (clk),
    .clr         (clr),
    .hsync       (hsync),
    .de          (de),
    .frame_start (fs_s),
    .x           (x),
    .y           (y)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunken raster (15x8) for frame-level behaviour plus a full-size
// instance for one 800-clock line. Frame counter checks only when VGA_SYNC_FRAME_CNT_EN is defined.

module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       start_b;
  logic       hs, vs, de, fs;
  logic [9:0] x, y;
  logic       b_hs, b_vs, b_de, b_fs;
  logic [9:0] b_x, b_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] fcnt;
  logic [7:0] b_fcnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Small raster: H 8+2+3+2 = 15, V 4+1+2+1 = 8, frame = 120 clocks
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .clr(clr), .start(start),
    .hsync(hs), .vsync(vs), .de(de), .x(x), .y(y),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_cnt(fcnt),
`endif
    .frame_start(fs)
  );

  vga_sync_gen u_big (
    .clk(clk), .clr(clr), .start(start_b),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_cnt(b_fcnt),
`endif
    .frame_start(b_fs)
  );

  typedef struct {
    int   adv;
    logic st;
    logic hs;
    logic vs;
    logic de;
    int   x;
    int   y;
    logic fs;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, nfs, nde, nvs, nhs, first_vs, fs_idx1, first_hs, maxx;
    bit ok;

    tbl[0]  = '{3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1};
    tbl[2]  = '{7,  1'b1, 1'b1, 1'b1, 1'b1, 7, 0, 1'b0};
    tbl[3]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[4]  = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[5]  = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[6]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[7]  = '{3,  1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[8]  = '{36, 1'b1, 1'b1, 1'b1, 1'b1, 7, 3, 1'b0};
    tbl[9]  = '{8,  1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[10] = '{15, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[11] = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[12] = '{20, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[13] = '{14, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[14] = '{1,  1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1};

    clr = 1'b0; start = 1'b0; start_b = 1'b0;
    #1 clr = 1'b1;
    #11 clr = 1'b0;

    // Idle with start low for 1000 clocks
    bad = 0; nfs = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (fs !== 1'b0) nfs++;
      if (hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0 || x !== 10'd0 || y !== 10'd0) bad++;
    end
    chk("idle_frame_start", nfs, 0);
    chk("idle_outputs", bad, 0);

    // Directed raster vectors over the first frame
    for (int i = 0; i < 15; i++) begin
      start = tbl[i].st;
      tick(tbl[i].adv);
      chk($sformatf("vec%0d_hsync", i), int'(hs), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vsync", i), int'(vs), int'(tbl[i].vs));
      chk($sformatf("vec%0d_de", i), int'(de), int'(tbl[i].de));
      chk($sformatf("vec%0d_x", i), int'(x), tbl[i].x);
      chk($sformatf("vec%0d_y", i), int'(y), tbl[i].y);
      chk($sformatf("vec%0d_fs", i), int'(fs), int'(tbl[i].fs));
    end

    // Two full frames starting at a frame_start sample
    nfs = 0; nde = 0; nvs = 0; nhs = 0; first_vs = -1; fs_idx1 = -1;
    for (int i = 0; i < 240; i++) begin
      if (fs === 1'b1) begin
        nfs++;
        if (i > 0 && fs_idx1 < 0) fs_idx1 = i;
      end
      if (de === 1'b1) nde++;
      if (hs === 1'b0) nhs++;
      if (vs === 1'b0) begin
        nvs++;
        if (first_vs < 0) first_vs = i;
      end
      tick(1);
    end
    chk("two_frames_fs_count", nfs, 2);
    chk("fs_period", fs_idx1, 120);
    chk("de_count_2frames", nde, 64);
    chk("hsync_low_2frames", nhs, 48);
    chk("vsync_low_2frames", nvs, 60);
    chk("vsync_first_low_idx", first_vs, 75);

    // Drop start mid-frame at h=3, v=2: frame must finish, then IDLE
    tick(33);
    start = 1'b0;
    nfs = 0; nde = 0; nvs = 0; bad = 0;
    for (int i = 0; i < 137; i++) begin
      if (fs === 1'b1) nfs++;
      if (de === 1'b1) nde++;
      if (vs === 1'b0) nvs++;
      if (i >= 87 && (hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0)) bad++;
      tick(1);
    end
    chk("stop_de_rest", nde, 13);
    chk("stop_vsync_low", nvs, 30);
    chk("stop_no_fs", nfs, 0);
    chk("stop_idle_after", bad, 0);

    // Asynchronous clr between edges at h=3, v=2
    start = 1'b1;
    tick(1);
    chk("restart_fs", int'(fs), 1);
    tick(33);
    chk("pre_clr_de", int'(de), 1);
    chk("pre_clr_x", int'(x), 3);
    #2 clr = 1'b1;
    #1;
    chk("clr_async_de", int'(de), 0);
    chk("clr_async_xy", int'(x) + int'(y), 0);
    chk("clr_async_sync", int'(hs) + int'(vs), 2);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("clr_held_fs", int'(fs), 0);
    tick(1);
    chk("post_clr_fs", int'(fs), 1);
    chk("post_clr_de", int'(de), 1);

    // Full-size line on the default-parameter instance
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    chk("big_first_fs", int'(b_fs), 1);
    nde = 0; nhs = 0; first_hs = -1; nvs = 0; maxx = 0;
    for (int i = 0; i < 800; i++) begin
      if (b_de === 1'b1) nde++;
      if (b_vs === 1'b0 || b_y !== 10'd0) nvs++;
      if (int'(b_x) > maxx) maxx = int'(b_x);
      if (b_hs === 1'b0) begin
        nhs++;
        if (first_hs < 0) first_hs = i;
      end
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (i == 1) chk("big_frame_cnt", int'(b_fcnt), 1);
`endif
      tick(1);
    end
    chk("big_de_count", nde, 640);
    chk("big_hsync_low", nhs, 96);
    chk("big_hsync_first", first_hs, 656);
    chk("big_line0_vsync_y", nvs, 0);
    chk("big_max_x", maxx, 639);

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Frame counter over 257 frames from a fresh reset
    #2 clr = 1'b1;
    #2 clr = 1'b0;
    start = 1'b1;
    tick(1);
    chk("fcnt_reset", int'(fcnt), 0);
    for (int k = 1; k <= 257; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (fs === 1'b1) begin
          ok = 1'b1;
          break;
        end
        tick(1);
      end
      if (!ok) begin
        chk("fcnt_wait_fs", 0, 1);
        break;
      end
      tick(1);
      if (k == 1 || k == 255 || k == 256 || k == 257)
        chk($sformatf("fcnt_frame%0d", k), int'(fcnt), k % 256);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
